// File: rtl/clock_pkg.sv
// Shared clocking definitions: sequencer state encoding, default timing constants
// and the counter-width helper used by the PLL reset sequencer.
`timescale 1ns/1ps
package clock_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES = 32;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRY      = 7;

    localparam int           RETRY_W   = 3;
    localparam logic [2:0]   RETRY_SAT = 3'd7;

    // Counters only ever hold (parameter - 1), so the width covers the largest value minus one.
    function automatic int count_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-facing and downstream-facing signals of the reset sequencer.
// master = sequencer side, slave = PLL model / downstream consumer side.
`timescale 1ns/1ps
interface pll_reset_sequencer_if;

    logic       PLL_LOCK;
    logic       PLL_RESET;
    logic       READY;
    logic       LOCK_LOST;
    logic       FAIL;
    logic [2:0] RETRY_CNT;

    modport master (
        input  PLL_LOCK,
        output PLL_RESET,
        output READY,
        output LOCK_LOST,
        output FAIL,
        output RETRY_CNT
    );

    modport slave (
        output PLL_LOCK,
        input  PLL_RESET,
        input  READY,
        input  LOCK_LOST,
        input  FAIL,
        input  RETRY_CNT
    );

endinterface

// File: rtl/sync_ff.sv
// Two-flop synchronizer for a single asynchronous level (PLL or TMDS lock).
`timescale 1ns/1ps
module sync_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the rPLL in reset, waits for a qualified lock and produces a registered
// READY; re-resets on timeout and gives up into a sticky FAIL after MAX_RETRY tries.
`timescale 1ns/1ps
module pll_reset_sequencer
    import clock_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_n,
    pll_reset_sequencer_if.master  bus
);

    localparam int CNT_W = count_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cnt_dec;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic               lost_next;
    logic               lk;

    logic               pll_reset_q;
    logic               ready_q;
    logic               lock_lost_q;
    logic               fail_q;

    sync_ff u_lock_sync (
        .clk   (CLK_IN),
        .rst_n (RESET_n),
        .d     (bus.PLL_LOCK),
        .q     (lk)
    );

    assign cnt_dec   = (cnt == '0) ? cnt : cnt - 1'b1;
    assign retry_inc = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 1'b1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt_dec;
        retry_next = retry_cnt;
        lost_next  = 1'b0;

        case (state)
            PLL_RST: begin
                if (cnt == '0) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end
            end

            // Lock is checked before the timeout so a late lock still wins.
            WAIT_LOCK: begin
                if (lk) begin
                    state_next = STABLE;
                    cnt_next   = STABLE_LOAD;
                end else if (cnt == '0) begin
                    retry_next = retry_inc;
                    if (retry_cnt == RETRY_LAST) begin
                        state_next = FAIL;
                    end else begin
                        state_next = PLL_RST;
                        cnt_next   = RST_LOAD;
                    end
                end
            end

            STABLE: begin
                if (!lk) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (cnt == '0) begin
                    state_next = RUN;
                    retry_next = '0;
                end
            end

            RUN: begin
                retry_next = '0;
                if (!lk) begin
                    state_next = PLL_RST;
                    cnt_next   = RST_LOAD;
                    lost_next  = 1'b1;
                end
            end

            FAIL: begin
                state_next = FAIL;
            end

            default: begin
                state_next = PLL_RST;
                cnt_next   = RST_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change on the same
    // edge as the state and can never glitch into the PLL or downstream resets.
    always_ff @(posedge CLK_IN or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= PLL_RST;
            cnt         <= RST_LOAD;
            retry_cnt   <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            retry_cnt   <= retry_next;
            pll_reset_q <= (state_next == PLL_RST) || (state_next == FAIL);
            ready_q     <= (state_next == RUN);
            lock_lost_q <= lost_next;
            fail_q      <= (state_next == FAIL);
        end
    end

    assign bus.PLL_RESET = pll_reset_q;
    assign bus.READY     = ready_q;
    assign bus.LOCK_LOST = lock_lost_q;
    assign bus.FAIL      = fail_q;
    assign bus.RETRY_CNT = retry_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; edge numbers
// in the step comments count rising CLK_IN edges after the most recent reset release.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
    import clock_pkg::*;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 16;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRY      = 7;

    logic CLK_IN;
    logic RESET_n;
    int   check_count;
    int   pass_count;
    int   fail_count;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .CLK_IN  (CLK_IN),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        check_count  = 0;
        pass_count   = 0;
        fail_count   = 0;
        RESET_n      = 1'b0;
        bus.PLL_LOCK = 1'b0;
        step(3);

        check_output("rst_pll_reset", 32'(bus.PLL_RESET), 32'd1);
        check_output("rst_ready",     32'(bus.READY),     32'd0);
        check_output("rst_lock_lost", 32'(bus.LOCK_LOST), 32'd0);
        check_output("rst_fail",      32'(bus.FAIL),      32'd0);
        check_output("rst_retry",     32'(bus.RETRY_CNT), 32'd0);
        check_output("rst_state",     32'(dut.state),     32'(PLL_RST));
        check_output("rst_cnt",       32'(dut.cnt),       32'd3);

        // Normal bring-up: lock first sampled at edge 10, READY expected at edge 20.
        RESET_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check_output("pulse1_high", 32'(bus.PLL_RESET), 32'd1);
        end
        step(1);
        check_output("pulse1_end", 32'(bus.PLL_RESET), 32'd0);
        step(5);
        bus.PLL_LOCK = 1'b1;
        step(10);
        check_output("ready_early", 32'(bus.READY), 32'd0);
        step(1);
        check_output("ready_rise",   32'(bus.READY),     32'd1);
        check_output("run_retry",    32'(bus.RETRY_CNT), 32'd0);
        check_output("run_lostidle", 32'(bus.LOCK_LOST), 32'd0);

        // One-cycle lock drop in RUN, launched after edge 22.
        step(2);
        bus.PLL_LOCK = 1'b0;
        step(1);
        bus.PLL_LOCK = 1'b1;
        check_output("drop_ready_e23", 32'(bus.READY), 32'd1);
        step(1);
        check_output("drop_ready_e24", 32'(bus.READY), 32'd1);
        step(1);
        check_output("drop_ready_fall", 32'(bus.READY),     32'd0);
        check_output("drop_lost_pulse", 32'(bus.LOCK_LOST), 32'd1);
        check_output("drop_rst_start",  32'(bus.PLL_RESET), 32'd1);
        step(1);
        check_output("drop_lost_end",   32'(bus.LOCK_LOST), 32'd0);
        check_output("drop_rst_e26",    32'(bus.PLL_RESET), 32'd1);
        step(2);
        check_output("drop_rst_e28",    32'(bus.PLL_RESET), 32'd1);
        step(1);
        check_output("drop_rst_end",    32'(bus.PLL_RESET), 32'd0);

        // STABLE entered at edge 30; lk low is seen while cnt==3 at edge 35.
        step(3);
        bus.PLL_LOCK = 1'b0;
        step(2);
        check_output("stable_state", 32'(dut.state), 32'(STABLE));
        check_output("stable_cnt3",  32'(dut.cnt),   32'd3);
        step(1);
        check_output("stable_back_state", 32'(dut.state),     32'(WAIT_LOCK));
        check_output("stable_back_cnt",   32'(dut.cnt),       32'd15);
        check_output("stable_back_ready", 32'(bus.READY),     32'd0);
        check_output("stable_back_retry", 32'(bus.RETRY_CNT), 32'd0);

        // No lock from here: reloaded timeout expires at edge 51, then every 20 cycles.
        step(15);
        check_output("to1_before_rst",   32'(bus.PLL_RESET), 32'd0);
        check_output("to1_before_retry", 32'(bus.RETRY_CNT), 32'd0);
        step(1);
        check_output("to1_rst",   32'(bus.PLL_RESET), 32'd1);
        check_output("to1_retry", 32'(bus.RETRY_CNT), 32'd1);
        for (int j = 1; j <= 5; j++) begin
            step(19);
            check_output("retry_wait_rst", 32'(bus.PLL_RESET), 32'd0);
            check_output("retry_wait_cnt", 32'(bus.RETRY_CNT), 32'(j));
            step(1);
            check_output("retry_rst",      32'(bus.PLL_RESET), 32'd1);
            check_output("retry_cnt",      32'(bus.RETRY_CNT), 32'(j + 1));
        end
        step(19);
        check_output("prefail_flag",  32'(bus.FAIL),      32'd0);
        check_output("prefail_rst",   32'(bus.PLL_RESET), 32'd0);
        check_output("prefail_retry", 32'(bus.RETRY_CNT), 32'd6);
        step(1);
        check_output("fail_flag",  32'(bus.FAIL),      32'd1);
        check_output("fail_rst",   32'(bus.PLL_RESET), 32'd1);
        check_output("fail_retry", 32'(bus.RETRY_CNT), 32'd7);
        check_output("fail_ready", 32'(bus.READY),     32'd0);
        bus.PLL_LOCK = 1'b1;
        step(30);
        check_output("fail_sticky", 32'(bus.FAIL),      32'd1);
        check_output("fail_rst_hi", 32'(bus.PLL_RESET), 32'd1);
        check_output("fail_noready",32'(bus.READY),     32'd0);

        // Asynchronous reset while in FAIL, mid-cycle.
        #4;
        RESET_n = 1'b0;
        #1;
        check_output("rstfail_flag",  32'(bus.FAIL),      32'd0);
        check_output("rstfail_rst",   32'(bus.PLL_RESET), 32'd1);
        check_output("rstfail_retry", 32'(bus.RETRY_CNT), 32'd0);
        check_output("rstfail_ready", 32'(bus.READY),     32'd0);
        check_output("rstfail_state", 32'(dut.state),     32'(PLL_RST));
        step(2);
        bus.PLL_LOCK = 1'b0;
        RESET_n      = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check_output("pulse2_high", 32'(bus.PLL_RESET), 32'd1);
        end
        step(1);
        check_output("pulse2_end", 32'(bus.PLL_RESET), 32'd0);

        // lk rises exactly when the timeout count is 0 (decision at edge 20).
        step(13);
        bus.PLL_LOCK = 1'b1;
        step(2);
        check_output("race_pre_state", 32'(dut.state), 32'(WAIT_LOCK));
        check_output("race_pre_cnt",   32'(dut.cnt),   32'd0);
        step(1);
        check_output("race_state", 32'(dut.state),     32'(STABLE));
        check_output("race_retry", 32'(bus.RETRY_CNT), 32'd0);
        step(7);
        check_output("race_ready_early", 32'(bus.READY), 32'd1 - 32'd1);
        step(1);
        check_output("race_ready_rise",  32'(bus.READY), 32'd1);

        // Asynchronous reset while in RUN; the PLL model drops lock while held in reset.
        step(3);
        #4;
        RESET_n      = 1'b0;
        bus.PLL_LOCK = 1'b0;
        #1;
        check_output("rstrun_ready", 32'(bus.READY),     32'd0);
        check_output("rstrun_rst",   32'(bus.PLL_RESET), 32'd1);
        check_output("rstrun_lost",  32'(bus.LOCK_LOST), 32'd0);
        check_output("rstrun_state", 32'(dut.state),     32'(PLL_RST));
        check_output("rstrun_cnt",   32'(dut.cnt),       32'd3);
        step(2);
        RESET_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check_output("pulse3_high", 32'(bus.PLL_RESET), 32'd1);
        end
        step(1);
        check_output("pulse3_end", 32'(bus.PLL_RESET), 32'd0);
        bus.PLL_LOCK = 1'b1;
        step(10);
        check_output("min_ready_edge14", 32'(bus.READY), 32'd0);
        step(1);
        check_output("min_ready_edge15", 32'(bus.READY),     32'd1);
        check_output("min_ready_retry",  32'(bus.RETRY_CNT), 32'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
